reg_file_32x32: RTL and testbench



---
 rtl/reg_file_32x32.sv | 75 +++++++
 tb/tb_reg_file_32x32.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/reg_file_32x32.sv
// 2-read / 1-write register file with x0 hardwired to zero and same-cycle
// write-through bypass on both read ports.

module reg_file_32x32_rdport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic                         rst,
    input  logic                         we,
    input  logic [ADDR_W-1:0]            wa,
    input  logic [DATA_W-1:0]            wd,
    input  logic [DEPTH-1:0][DATA_W-1:0] mem,
    input  logic [ADDR_W-1:0]            ra,
    output logic [DATA_W-1:0]            rd
);
    // Bypass is a single 2:1 after the storage mux; suppressed during reset.
    always_comb begin
        rd = mem[ra];
        if (ra == '0)
            rd = '0;
        else if (!rst && we && (wa == ra))
            rd = wd;
    end
endmodule

module reg_file_32x32 #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd
);
    localparam int DEPTH     = 2**ADDR_W;
    localparam int NUM_PORTS = 2;

    logic [DEPTH-1:0][DATA_W-1:0]     mem;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] ra;
    logic [NUM_PORTS-1:0][DATA_W-1:0] rd;

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (rst)
            mem <= '0;
        else if (we && (wa != '0))
            mem[wa] <= wd;
    end

    assign ra  = {ra2, ra1};
    assign rd1 = rd[0];
    assign rd2 = rd[1];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
        reg_file_32x32_rdport #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH)
        ) u_rd (
            .rst (rst),
            .we  (we),
            .wa  (wa),
            .wd  (wd),
            .mem (mem),
            .ra  (ra[p]),
            .rd  (rd[p])
        );
    end
endmodule

// File: tb/tb_reg_file_32x32.sv
// Scoreboarded bench for reg_file_32x32: driver pushes model-predicted read
// data, a negedge monitor pops and compares against the DUT outputs.

module tb_reg_file_32x32;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we  = 1'b0;
    logic [4:0]  wa  = '0;
    logic [4:0]  ra1 = '0;
    logic [4:0]  ra2 = '0;
    logic [31:0] wd  = '0;
    logic [31:0] rd1, rd2;

    always #5 clk = ~clk;

    reg_file_32x32 #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .ra1 (ra1),
        .ra2 (ra2),
        .rd1 (rd1),
        .rd2 (rd2),
        .we  (we),
        .wa  (wa),
        .wd  (wd)
    );

    typedef struct {
        string       tag;
        logic [31:0] e1;
        logic [31:0] e2;
        bit          and_chk;
    } exp_t;

    exp_t        q[$];
    exp_t        me;
    logic [31:0] m[32];
    int          total = 0;
    int          bad   = 0;

    // Architectural view: x0 reads zero, a live write is visible at once
    // unless reset is held, otherwise the stored value.
    function automatic logic [31:0] ref_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (!rst && we && (wa == a)) return wd;
        return m[a];
    endfunction

    task automatic step(input bit r, input bit w, input logic [4:0] a,
                        input logic [31:0] d, input logic [4:0] p1,
                        input logic [4:0] p2, input bit chk,
                        input string tag, input bit andc = 1'b0);
        exp_t e;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m[i] = 32'h0;
        end else if (we && (wa != 5'd0)) begin
            m[wa] = wd;
        end
        #1;
        rst = r; we = w; wa = a; wd = d; ra1 = p1; ra2 = p2;
        if (chk) begin
            e.tag = tag;
            e.e1 = ref_rd(p1);
            e.e2 = ref_rd(p2);
            e.and_chk = andc;
            q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            total++;
            if (rd1 !== me.e1) begin
                bad++;
                $display("FAIL %s rd1 got=%h want=%h (ra1=%0d)", me.tag, rd1, me.e1, ra1);
            end
            total++;
            if (rd2 !== me.e2) begin
                bad++;
                $display("FAIL %s rd2 got=%h want=%h (ra2=%0d)", me.tag, rd2, me.e2, ra2);
            end
            if (me.and_chk) begin
                total++;
                if ((rd1 & rd2) !== 32'h05050505) begin
                    bad++;
                    $display("FAIL %s alu_and got=%h want=%h", me.tag, rd1 & rd2, 32'h05050505);
                end
            end
        end
    end

    initial begin
        logic [4:0]  a, p1, p2;
        logic [31:0] d;
        bit          r, w;

        // Reset: contents undefined until the first reset edge.
        step(1, 0, 0, 0, 0, 0, 0, "init");
        step(0, 1, 5, 32'hDEADBEEF, 5, 31, 1, "preload_bypass");
        step(1, 1, 5, 32'h00001234, 5, 31, 1, "rst_cycle_no_bypass");
        step(0, 0, 0, 0, 5, 31, 1, "after_reset");
        step(1, 0, 0, 0, 5, 31, 1, "rst_held");

        // Basic write/read plus ALU AND of the two operands.
        step(0, 1, 7, 32'hA5A5A5A5, 7, 8, 1, "wr_x7");
        step(0, 1, 8, 32'h0F0F0F0F, 7, 8, 1, "wr_x8");
        step(0, 0, 0, 0, 7, 8, 1, "rd_x7_x8", 1);

        // x0 write discarded, nothing else disturbed.
        step(0, 1, 0, 32'hFFFFFFFF, 0, 0, 1, "wr_x0");
        step(0, 0, 0, 0, 0, 0, 1, "rd_x0");
        for (int i = 1; i < 32; i++)
            step(0, 0, 0, 0, 5'(i), 5'(32 - i), 1, "x0_sweep");

        // Bypass over an older stored value, then storage after the edge.
        step(0, 1, 3, 32'h11111111, 0, 0, 0, "wr_x3");
        step(0, 1, 3, 32'h22222222, 3, 3, 1, "bypass_x3");
        step(0, 0, 0, 0, 3, 3, 1, "stored_x3");

        // Address sweep, then write-disabled idling.
        for (int i = 1; i < 32; i++)
            step(0, 1, 5'(i), 32'(i) * 32'h01010101, 0, 5'(i), 1, "sweep_wr");
        for (int i = 0; i < 10; i++)
            step(0, 0, 5'($urandom), $urandom, 5'($urandom), 5'($urandom), 1, "we0_idle");
        for (int i = 1; i < 32; i++)
            step(0, 0, 0, 0, 5'(i), 5'(32 - i), 1, "sweep_rd");

        // Randomized with sparse reset.
        for (int i = 0; i < 10000; i++) begin
            r  = ($urandom_range(0, 63) == 0);
            w  = $urandom_range(0, 1);
            a  = 5'($urandom);
            d  = $urandom;
            p1 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom);
            p2 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom);
            step(r, w, a, d, p1, p2, 1, "random");
        end

        repeat (3) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain pending got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
